// File: rtl/player_input_conditioner.sv
// player_input_conditioner
// N-channel button front end: polarity normalisation, flip-flop synchroniser,
// counter-based debounce, press/release pulses and a first-presser latch used
// for race-start and finish arbitration. Single clock domain.
module player_input_conditioner #(
    parameter int NUM_CH           = 4,
    parameter int DEBOUNCE_CLK_CNT = 65536,
    parameter int SYNC_STAGES      = 2,
    parameter bit ACTIVE_LOW       = 1'b0,
    localparam int ID_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] btn_in,
    input  logic              enable,
    input  logic              first_clear,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] btn_press,
    output logic [NUM_CH-1:0] btn_release,
    output logic              first_valid,
    output logic [ID_W-1:0]   first_id
);

    localparam int CNT_W = $clog2(DEBOUNCE_CLK_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CLK_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_chain;
    logic [NUM_CH-1:0][CNT_W-1:0]       cnt;
    logic [NUM_CH-1:0]                  norm;
    logic [NUM_CH-1:0]                  synced;
    logic [NUM_CH-1:0]                  flip;
    logic [NUM_CH-1:0]                  rise;
    logic [NUM_CH-1:0]                  fall;
    logic [NUM_CH-1:0]                  press_next;
    logic [NUM_CH-1:0]                  release_next;

    // Lowest-numbered channel wins when several press on the same edge.
    function automatic logic [ID_W-1:0] lowest_index(input logic [NUM_CH-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

    // Inversion happens before the synchroniser so that reset (all zeros)
    // always means "not pressed", whatever the pin polarity.
    assign norm   = btn_in ^ {NUM_CH{ACTIVE_LOW}};
    assign synced = sync_chain[SYNC_STAGES-1];

    // Synchroniser: shift normalised pins through SYNC_STAGES flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], norm};
        end
    end

    // A channel flips on the edge where its mismatch count has completed.
    always_comb begin
        flip = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            flip[i] = (synced[i] != btn_level[i]) && (cnt[i] == CNT_LAST);
        end
    end

    assign rise         = flip & synced;
    assign fall         = flip & ~synced;
    assign press_next   = rise & {NUM_CH{enable}};
    assign release_next = fall & {NUM_CH{enable}};

    // Debounce: count consecutive mismatches, any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            btn_level <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (synced[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    btn_level[i] <= synced[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Press/release pulses registered on the same edge that flips the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            btn_press   <= press_next;
            btn_release <= release_next;
        end
    end

    // First-press latch: clear then capture, so a press on the clearing edge wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_valid <= 1'b0;
            first_id    <= '0;
        end else if ((press_next != '0) && (!first_valid || first_clear)) begin
            first_valid <= 1'b1;
            first_id    <= lowest_index(press_next);
        end else if (first_clear) begin
            first_valid <= 1'b0;
        end
    end

endmodule

// File: doc/player_input_conditioner.md
Name: player_input_conditioner

Overview:
- Parametrised N-channel successor to the per-button debouncers feeding the racer core.
- Synchronises, polarity-normalises and debounces NUM_CH player buttons, using one counter per channel.
- Produces a debounced level, one-cycle press and release pulses, and a "first presser" latch for race-start and finish arbitration.
- Sits between the board pins and LEDs_racer_core. All channels run in one clock domain.

Parameters:
- NUM_CH, 4: number of button channels (1..16).
- DEBOUNCE_CLK_CNT, 65536: consecutive cycles the synced input must differ from the debounced level before the level flips (>=2).
- SYNC_STAGES, 2: flip-flop synchroniser depth per channel (>=2).
- ACTIVE_LOW, 0: 1 = pins read 0 when pressed; the block inverts them before the synchroniser.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- btn_in  in  NUM_CH  raw button pins, bit i = channel i
- enable  in  1  1 = pulses and first-press capture are active
- first_clear  in  1  single-cycle request to re-arm the first-press latch
- btn_level  out  NUM_CH  debounced level, 1 = pressed
- btn_press  out  NUM_CH  one-cycle pulse on each debounced 0->1 transition
- btn_release  out  NUM_CH  one-cycle pulse on each debounced 1->0 transition
- first_valid  out  1  a first press has been captured since reset or the last clear
- first_id  out  $clog2(NUM_CH) (min 1)  index of the captured channel

Behaviour:
- Reset (rst_n low, asynchronous):
  - All synchroniser stages, btn_level, counters, btn_press, btn_release, first_valid and first_id go to 0.
  - The synchroniser resets to the inactive (normalised 0) value, so ACTIVE_LOW pins idling high produce no spurious press.
- Normalisation: n_i = btn_in[i] XOR ACTIVE_LOW, fed into a SYNC_STAGES-deep flip-flop chain whose output is s_i.
- Debounce, per channel on each clk edge:
  - If s_i == level_i: cnt_i <= 0.
  - Else if cnt_i == DEBOUNCE_CLK_CNT-1: level_i <= s_i and cnt_i <= 0.
  - Else: cnt_i <= cnt_i + 1.
  - Counter width is $clog2(DEBOUNCE_CLK_CNT). The counter never wraps.
- Latency: a clean pin change becomes visible on btn_level exactly SYNC_STAGES + DEBOUNCE_CLK_CNT edges later.
- Glitches: any bounce returning s_i to level_i before the count completes restarts the count from 0.
- Pulses:
  - btn_press[i] and btn_release[i] are registered on the same edge that flips level_i, and are high for exactly that one cycle.
  - They are gated by enable sampled on that edge. With enable=0 the level still flips but no pulse is emitted.
- First-press latch:
  - On an edge where first_valid==0 (or first_clear==1) and enable==1 and any btn_press condition is true: first_valid <= 1, first_id <= lowest index among the channels pressing this cycle.
  - first_clear with no press on the same edge: first_valid <= 0, first_id is held.
  - first_clear and a press on the same edge: the press is captured (clear, then capture).
  - While first_valid==1 and first_clear==0, further presses do not change first_id.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulses.
- Reset asserted mid-debounce discards the partial count. After release, an input held pressed needs the full latency again.

Test Plan:
- DEBOUNCE_CLK_CNT=4, SYNC_STAGES=2. Set btn_in[1]=1 before edge 1 and hold it -> btn_level[1]=1 and btn_press[1]=1 after edge 6. btn_press[1]=0 after edge 7. first_valid=1, first_id=1.
- btn_in[0] pulses high for 3 cycles, then returns low -> btn_level[0] stays 0; no press or release pulse; counter back at 0.
- btn_in[2] and btn_in[0] rise in the same cycle -> both press pulses fire on the same edge; first_id=0. A later press on channel 3 leaves first_id=0. Then first_clear followed by a channel-3 press -> first_id=3.
- enable=0 during a channel-1 press -> btn_level[1] rises after 6 edges, btn_press[1] never asserts, first_valid stays 0. Releasing with enable=1 -> btn_release[1] pulses once, 6 edges after the release.
- rst_n pulled low for 1 cycle at cycle 4 of a channel-2 debounce, pin still held -> all outputs are 0 during reset. btn_press[2] fires 6 edges after rst_n rises.
- ACTIVE_LOW=1, all pins idle high through and after reset -> no pulses and btn_level=0. Pin 3 driven low -> btn_level[3]=1 after 6 edges.
